alu_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one `Alu16bit` instance between two requesters, such as the execute stage and a multi-cycle helper unit. It accepts one operation at a time over a valid/ready handshake and registers the operands into the ALU. It captures Result and the flags, then holds them on a response handshake until the owning requester consumes them. It sits between the requesters and the ALU, and owns every ALU input.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/Alu16bit.sv | 52 +++++
 rtl/alu_share_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: opcode encodings, datapath widths and the arbiter FSM state type.
package alu_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_SLT  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_ADDI = 3'b101;
    localparam logic [2:0] ALU_SLL  = 3'b110;
    localparam logic [2:0] ALU_SRA  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/Alu16bit.sv
// Combinational 16-bit ALU: logic ops, signed set-less-than, add/sub and shifts.
// Zero latency, no flow control; Overflow/CarryOut are only meaningful for ADD/ADDI.
module Alu16bit #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic [DATA_W-1:0]  A,
    input  logic [DATA_W-1:0]  B,
    input  logic               BInvert,
    input  logic [2:0]         ALUOp,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               Zero,
    output logic               Overflow,
    output logic [DATA_W-1:0]  Result,
    output logic               CarryOut
);
    import alu_pkg::*;

    logic              do_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              ovf;
    logic              is_add;

    // SLT always subtracts so the sign test is valid regardless of BInvert.
    always_comb begin
        do_sub = BInvert | (ALUOp == ALU_SLT);
        b_eff  = do_sub ? ~B : B;
        sum    = {1'b0, A} + {1'b0, b_eff} + {{DATA_W{1'b0}}, do_sub};
        ovf    = (A[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
        is_add = (ALUOp == ALU_ADD) || (ALUOp == ALU_ADDI);
    end

    always_comb begin
        Result = '0;
        case (ALUOp)
            ALU_AND:  Result = A & B;
            ALU_SLT:  Result = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ ovf};
            ALU_OR:   Result = A | B;
            ALU_XOR:  Result = A ^ B;
            ALU_ADD,
            ALU_ADDI: Result = sum[DATA_W-1:0];
            ALU_SLL:  Result = A << Shamt;
            ALU_SRA:  Result = $signed(A) >>> Shamt;
            default:  Result = '0;
        endcase
        Zero     = (Result == '0);
        Overflow = is_add & ovf;
        CarryOut = is_add & sum[DATA_W];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one Alu16bit between two requesters; one op in flight.
// Response valid two cycles after accept; ReqReady low until the owner takes the response.
module alu_share_arbiter #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [1:0]         ReqValid,
    output logic [1:0]         ReqReady,
    input  logic [DATA_W-1:0]  ReqA0,
    input  logic [DATA_W-1:0]  ReqA1,
    input  logic [DATA_W-1:0]  ReqB0,
    input  logic [DATA_W-1:0]  ReqB1,
    input  logic [2:0]         ReqALUOp0,
    input  logic [2:0]         ReqALUOp1,
    input  logic               ReqBInvert0,
    input  logic               ReqBInvert1,
    input  logic [SHAMT_W-1:0] ReqShamt0,
    input  logic [SHAMT_W-1:0] ReqShamt1,
    output logic [1:0]         RspValid,
    input  logic [1:0]         RspReady,
    output logic [DATA_W-1:0]  RspResult,
    output logic               RspZero,
    output logic               RspOverflow,
    output logic               RspCarryOut,
    output logic               Busy
);
    import alu_pkg::*;

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic               own_q, own_d;
    logic               gnt;
    logic               req_fire;

    logic [DATA_W-1:0]  op_a_q, op_b_q;
    logic [2:0]         op_alu_q;
    logic               op_binv_q;
    logic [SHAMT_W-1:0] op_shamt_q;

    logic [DATA_W-1:0]  rsp_res_q;
    logic               rsp_zero_q, rsp_ovf_q, rsp_cout_q;

    logic [DATA_W-1:0]  alu_res;
    logic               alu_zero, alu_ovf, alu_cout;

    Alu16bit #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_alu (
        op_a_q, op_b_q, op_binv_q, op_alu_q, op_shamt_q,
        alu_zero, alu_ovf, alu_res, alu_cout
    );

    // A lone requester wins outright; a tie goes to the priority holder.
    always_comb begin
        case (ReqValid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = prio_q;
        endcase
        req_fire = (state_q == ST_IDLE) && ReqValid[gnt] && !Reset;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            own_q      <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_alu_q   <= '0;
            op_binv_q  <= 1'b0;
            op_shamt_q <= '0;
            rsp_res_q  <= '0;
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_cout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            own_q   <= own_d;
            if (req_fire) begin
                op_a_q     <= gnt ? ReqA1       : ReqA0;
                op_b_q     <= gnt ? ReqB1       : ReqB0;
                op_alu_q   <= gnt ? ReqALUOp1   : ReqALUOp0;
                op_binv_q  <= gnt ? ReqBInvert1 : ReqBInvert0;
                op_shamt_q <= gnt ? ReqShamt1   : ReqShamt0;
            end
            if (state_q == ST_EXEC) begin
                rsp_res_q  <= alu_res;
                rsp_zero_q <= alu_zero;
                rsp_ovf_q  <= alu_ovf;
                rsp_cout_q <= alu_cout;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        own_d   = own_q;
        case (state_q)
            ST_IDLE: if (req_fire) begin
                state_d = ST_EXEC;
                own_d   = gnt;
                prio_d  = ~gnt;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (RspReady[own_q]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ReqReady    = req_fire ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        RspValid    = (state_q == ST_RESP) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
        Busy        = (state_q != ST_IDLE);
        RspResult   = rsp_res_q;
        RspZero     = rsp_zero_q;
        RspOverflow = rsp_ovf_q;
        RspCarryOut = rsp_cout_q;
    end

endmodule
